// File: rtl/gb_video_pkg.sv
// Shared Game Boy video types, framebuffer geometry and shade palettes.
// GB_GREEN_PALETTE_EN selects the DMG green palette instead of grayscale.
package gb_video_pkg;

    localparam int GB_W = 160;
    localparam int GB_H = 144;

    typedef logic [1:0] shade_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic {
        IDLE,
        FETCH
    } fetch_state_t;

    // Index 0 is the lightest shade
    localparam rgb_t [3:0] PAL_GRAY = {
        24'h000000, 24'h555555, 24'hAAAAAA, 24'hFFFFFF
    };
    localparam rgb_t [3:0] PAL_GREEN = {
        24'h0F380F, 24'h306230, 24'h8BAC0F, 24'h9BBC0F
    };

`ifdef GB_GREEN_PALETTE_EN
    localparam bit GREEN_EN = 1'b1;
`else
    localparam bit GREEN_EN = 1'b0;
`endif

    function automatic rgb_t pal_lookup(shade_t s);
        return GREEN_EN ? PAL_GREEN[s] : PAL_GRAY[s];
    endfunction

endpackage

// File: rtl/gb_vga_scaler_if.sv
// Bundle between VGA timing/framebuffer side and the GB scaler.
// slave = scaler view, master = timing generator / framebuffer / sink view.
interface gb_vga_scaler_if;
    import gb_video_pkg::*;

    logic        pix_ce;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        hs_in;
    logic        vs_in;
    logic        blank_in;
    logic        fb_rd;
    logic [14:0] fb_addr;
    shade_t      fb_rdata;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK_N;
    logic        frame_start;
    logic        fetch_busy;

    modport slave (
        input  pix_ce, DrawX, DrawY, hs_in, vs_in, blank_in, fb_rdata,
        output fb_rd, fb_addr, VGA_R, VGA_G, VGA_B,
        output VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, fetch_busy
    );

    modport master (
        output pix_ce, DrawX, DrawY, hs_in, vs_in, blank_in, fb_rdata,
        input  fb_rd, fb_addr, VGA_R, VGA_G, VGA_B,
        input  VGA_HS, VGA_VS, VGA_BLANK_N, frame_start, fetch_busy
    );

endinterface

// File: rtl/gb_line_buffer.sv
// One GB row of shades: simple dual-port RAM, sync write, registered read.
module gb_line_buffer
    import gb_video_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_we,
    input  logic [7:0] i_waddr,
    input  shade_t     i_wdata,
    input  logic [7:0] i_raddr,
    output shade_t     o_rdata
);

    shade_t r_mem [GB_W];
    shade_t r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/gb_vga_scaler.sv
// Upscales and centres the 160x144 GB framebuffer on 640x480 VGA timing.
// Palette chosen at build time by GB_GREEN_PALETTE_EN (see gb_video_pkg).
module gb_vga_scaler
    import gb_video_pkg::*;
#(
    parameter int SCALE = 3,
    parameter int X_OFF = 80,
    parameter int Y_OFF = 24
) (
    input  logic            Clk,
    input  logic            Reset_n,
    gb_vga_scaler_if.slave  bus
);

    localparam int          SW       = $clog2(SCALE + 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
    localparam logic [9:0]  X_BEG    = 10'(X_OFF);
    localparam logic [9:0]  X_END    = 10'(X_OFF + GB_W * SCALE);
    localparam logic [9:0]  Y_BEG    = 10'(Y_OFF);
    localparam logic [9:0]  Y_END    = 10'(Y_OFF + GB_H * SCALE);
    localparam logic [9:0]  FETCH_X  = 10'd640;
    localparam logic [9:0]  LAST_Y   = 10'd524;
    localparam logic [9:0]  VBLANK_Y = 10'd480;
    localparam logic [7:0]  COL_LAST = 8'(GB_W - 1);
    localparam logic [14:0] ROW_STEP = 15'(GB_W);

    fetch_state_t    r_state;
    logic            r_rd;
    logic            r_busy;
    logic            r_we;
    logic [14:0]     r_addr;
    logic [7:0]      r_fcol;
    logic [7:0]      r_wcol;
    logic [SW-1:0]   r_sub_row;
    logic [14:0]     r_row_base;
    logic [SW-1:0]   r_sub_col;
    logic [7:0]      r_col;
    logic            r_inside;
    logic            r_hs1;
    logic            r_vs1;
    logic            r_blank1;
    rgb_t            r_rgb;
    logic            r_hs;
    logic            r_vs;
    logic            r_blank_n;
    logic            r_frame;

    shade_t          w_rdata;
    logic [9:0]      w_nl;
    logic            w_trig;
    logic            w_line_first;
    logic            w_line_in;
    logic            w_fetch;
    logic [14:0]     w_base;
    logic            w_inside;

    assign w_nl         = (bus.DrawY == LAST_Y) ? '0 : bus.DrawY + 10'd1;
    assign w_trig       = bus.pix_ce && (bus.DrawX == FETCH_X);
    assign w_line_first = (w_nl == Y_BEG);
    assign w_line_in    = (w_nl > Y_BEG) && (w_nl < Y_END);
    assign w_fetch      = w_trig && (w_line_first ||
                          (w_line_in && r_sub_row == SUB_LAST));
    assign w_base       = w_line_first ? '0 : r_row_base + ROW_STEP;

    // Row tracking for the line that follows the current hblank
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_sub_row  <= '0;
            r_row_base <= '0;
        end else if (w_trig) begin
            if (w_line_first) begin
                r_sub_row  <= '0;
                r_row_base <= '0;
            end else if (w_line_in) begin
                if (r_sub_row == SUB_LAST) begin
                    r_sub_row  <= '0;
                    r_row_base <= w_base;
                end else begin
                    r_sub_row <= r_sub_row + SW'(1);
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= IDLE;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_fcol  <= '0;
            r_wcol  <= '0;
        end else begin
            r_we   <= r_rd;
            r_wcol <= r_fcol;
            unique case (r_state)
                IDLE: begin
                    if (w_fetch) begin
                        r_state <= FETCH;
                        r_busy  <= 1'b1;
                        r_rd    <= 1'b1;
                        r_addr  <= w_base;
                        r_fcol  <= '0;
                    end
                end
                FETCH: begin
                    if (r_rd) begin
                        if (r_fcol == COL_LAST) begin
                            r_rd <= 1'b0;
                        end else begin
                            r_fcol <= r_fcol + 8'd1;
                            r_addr <= r_addr + 15'd1;
                        end
                    end
                    if (r_we && r_wcol == COL_LAST) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_inside = bus.blank_in
                    && bus.DrawX >= X_BEG && bus.DrawX < X_END
                    && bus.DrawY >= Y_BEG && bus.DrawY < Y_END;

    // Stage 1 picks the column and reads RAM; stage 2 drives the pins
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_sub_col <= '0;
            r_col     <= '0;
            r_inside  <= 1'b0;
            r_hs1     <= 1'b0;
            r_vs1     <= 1'b0;
            r_blank1  <= 1'b0;
            r_rgb     <= '0;
            r_hs      <= 1'b0;
            r_vs      <= 1'b0;
            r_blank_n <= 1'b0;
        end else if (bus.pix_ce) begin
            if (bus.DrawX == X_BEG) begin
                r_sub_col <= '0;
                r_col     <= '0;
            end else if (r_sub_col == SUB_LAST) begin
                r_sub_col <= '0;
                if (r_col != COL_LAST) begin
                    r_col <= r_col + 8'd1;
                end
            end else begin
                r_sub_col <= r_sub_col + SW'(1);
            end
            r_inside  <= w_inside;
            r_hs1     <= bus.hs_in;
            r_vs1     <= bus.vs_in;
            r_blank1  <= bus.blank_in;
            r_rgb     <= r_inside ? pal_lookup(w_rdata) : '0;
            r_hs      <= r_hs1;
            r_vs      <= r_vs1;
            r_blank_n <= r_blank1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_frame <= 1'b0;
        end else begin
            r_frame <= bus.pix_ce && bus.DrawX == '0
                    && bus.DrawY == VBLANK_Y;
        end
    end

    gb_line_buffer u_lbuf (
        .i_clk   (Clk),
        .i_we    (r_we),
        .i_waddr (r_wcol),
        .i_wdata (bus.fb_rdata),
        .i_raddr (r_col),
        .o_rdata (w_rdata)
    );

    assign bus.fb_rd       = r_rd;
    assign bus.fb_addr     = r_addr;
    assign bus.fetch_busy  = r_busy;
    assign bus.VGA_R       = r_rgb.r;
    assign bus.VGA_G       = r_rgb.g;
    assign bus.VGA_B       = r_rgb.b;
    assign bus.VGA_HS      = r_hs;
    assign bus.VGA_VS      = r_vs;
    assign bus.VGA_BLANK_N = r_blank_n;
    assign bus.frame_start = r_frame;

endmodule
